// File: rtl/tm1638_display_ctrl.sv
// TM1638 refresh sequencer: snapshots a 16-byte display image plus brightness and
// pushes it out as 18 handshaked words to an external SPI transmitter.
module tm1638_display_ctrl #(
   parameter int unsigned ACK_TIMEOUT = 8
) (
   input  logic          i_Clk,
   input  logic          i_Rst_n,
   input  logic          i_Update,
   input  logic [127:0]  i_Segments,
   input  logic [2:0]    i_Brightness,
   input  logic          i_Display_On,
   output logic          o_Busy,
   output logic          o_Done,
   output logic          o_SPI_Data_Ready,
   output logic [17:0]   o_SPI_Data,
   input  logic          i_SPI_Busy
);

   localparam int unsigned STEP_W = 5;
   localparam int unsigned DATA_W = 18;
   localparam int unsigned SEG_W  = 128;
   localparam int unsigned TO_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = 5'd17;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_ACK,
      ST_WAIT_DONE,
      ST_FINISH
   } state_e;

   state_e              state_q, state_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic                pending_q, pending_d;
   logic [SEG_W-1:0]    seg_q, seg_d;
   logic [2:0]          bright_q, bright_d;
   logic                on_q, on_d;
   logic                ready_q, ready_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [3:0]          seg_idx;
   logic [7:0]          seg_byte;
   logic [DATA_W-1:0]   word;
   logic                start;

   // Word for the current step, built from the snapshot registers
   always_comb begin
      seg_idx  = 4'(step_q - 5'd1);
      seg_byte = seg_q[{seg_idx, 3'b000} +: 8];
      if (step_q == '0) begin
         word = {1'b1, 1'b0, 8'h00, 8'h44};
      end else if (step_q == LAST_STEP) begin
         word = {1'b1, 1'b0, 8'h00, 8'h80 | {4'h0, on_q, bright_q}};
      end else begin
         word = {1'b1, 1'b1, seg_byte, 8'hC0 | {4'h0, seg_idx}};
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      to_cnt_d  = to_cnt_q;
      pending_d = pending_q;
      seg_d     = seg_q;
      bright_d  = bright_q;
      on_d      = on_q;
      ready_d   = 1'b0;
      data_d    = data_q;

      start = (state_q == ST_IDLE) && pending_q;
      if (start) begin
         pending_d = 1'b0;
      end else if (i_Update) begin
         pending_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (pending_q) begin
               seg_d    = i_Segments;
               bright_d = i_Brightness;
               on_d     = i_Display_On;
               step_d   = '0;
               state_d  = ST_SEND;
            end
         end
         // Strobe is raised while still in SEND; the strobe cycle itself moves on
         ST_SEND: begin
            if (ready_q) begin
               state_d  = ST_WAIT_ACK;
               to_cnt_d = '0;
            end else if (!i_SPI_Busy) begin
               ready_d = 1'b1;
               data_d  = word;
            end
         end
         ST_WAIT_ACK: begin
            if (i_SPI_Busy) begin
               state_d = ST_WAIT_DONE;
            end else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
               state_d  = ST_SEND;
               to_cnt_d = '0;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (!i_SPI_Busy) begin
               if (step_q == LAST_STEP) begin
                  state_d = ST_FINISH;
               end else begin
                  step_d  = step_q + 5'd1;
                  state_d = ST_SEND;
               end
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_FINISH);
   end

   // Pending comes out of reset set so the first refresh runs on its own
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q   <= ST_IDLE;
         step_q    <= '0;
         to_cnt_q  <= '0;
         pending_q <= 1'b1;
         seg_q     <= '0;
         bright_q  <= '0;
         on_q      <= 1'b0;
         ready_q   <= 1'b0;
         data_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         to_cnt_q  <= to_cnt_d;
         pending_q <= pending_d;
         seg_q     <= seg_d;
         bright_q  <= bright_d;
         on_q      <= on_d;
         ready_q   <= ready_d;
         data_q    <= data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign o_Busy           = busy_q;
   assign o_Done           = done_q;
   assign o_SPI_Data_Ready = ready_q;
   assign o_SPI_Data       = data_q;

endmodule

// File: tb/tb_tm1638_display_ctrl.sv
// Bench for tm1638_display_ctrl: SPI transmitter model with fixed busy time and
// optional dropped strobes, table of refresh vectors plus multi-cycle sequences.
module tb_tm1638_display_ctrl;

   localparam int BUSY_CYC = 20;
   localparam int MAX_WAIT = 3000;

   logic          clk;
   logic          rst_n;
   logic          update;
   logic [127:0]  segments;
   logic [2:0]    bright;
   logic          disp_on;
   logic          busy;
   logic          done;
   logic          spi_ready;
   logic [17:0]   spi_data;
   logic          spi_busy;

   tm1638_display_ctrl #(.ACK_TIMEOUT(8)) dut (
      .i_Clk            (clk),
      .i_Rst_n          (rst_n),
      .i_Update         (update),
      .i_Segments       (segments),
      .i_Brightness     (bright),
      .i_Display_On     (disp_on),
      .o_Busy           (busy),
      .o_Done           (done),
      .o_SPI_Data_Ready (spi_ready),
      .o_SPI_Data       (spi_data),
      .i_SPI_Busy       (spi_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // SPI model state and logs
   logic [17:0] words[$];
   logic [17:0] ign_word;
   int          strobe_cnt = 0;
   int          done_cnt = 0;
   int          ignore_left = 0;
   int          busy_cnt = 0;
   int          proto_err = 0;
   logic        prev_ready = 1'b0;
   logic        prev_done = 1'b0;

   initial spi_busy = 1'b0;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (done && prev_done) proto_err++;
      if (spi_ready && prev_ready) proto_err++;
      prev_done  = done;
      prev_ready = spi_ready;
      if (!rst_n) begin
         busy_cnt = 0;
         spi_busy = 1'b0;
      end else begin
         if (spi_ready) begin
            strobe_cnt++;
            if (ignore_left > 0) begin
               ignore_left--;
               ign_word = spi_data;
            end else begin
               words.push_back(spi_data);
               busy_cnt = BUSY_CYC;
            end
         end else if (busy_cnt > 0) begin
            busy_cnt--;
         end
         spi_busy = (busy_cnt != 0);
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_update();
      update = 1'b1;
      tick();
      update = 1'b0;
   endtask

   task automatic clear_logs();
      words.delete();
      strobe_cnt = 0;
      done_cnt = 0;
   endtask

   task automatic wait_done(input string name);
      int start;
      bit ok;
      start = done_cnt;
      ok = 1'b0;
      for (int c = 0; c < MAX_WAIT && !ok; c++) begin
         tick();
         if (done_cnt > start) ok = 1'b1;
      end
      if (!ok) begin
         errors++;
         $display("FAIL %s timeout waiting for done, got none expected pulse", name);
      end
   endtask

   function automatic logic [31:0] word_at(input int i);
      if (i < words.size()) return 32'(words[i]);
      return 32'hDEADBEEF;
   endfunction

   function automatic logic [17:0] exp_word(input logic [127:0] seg, input logic [2:0] br,
                                            input logic on, input int s);
      logic [7:0] b;
      if (s == 0) return 18'h20044;
      if (s == 17) return {2'b10, 8'h00, 8'h80 + {4'h0, on, br}};
      b = seg[8*(s-1) +: 8];
      return {2'b11, b, 8'hC0 + 8'(s-1)};
   endfunction

   task automatic check_seq(input string name, input logic [127:0] seg,
                            input logic [2:0] br, input logic on);
      int mism;
      mism = 0;
      chk({name, "_count"}, 32'(words.size()), 32'd18);
      for (int i = 0; i < 18; i++)
         if (word_at(i) !== 32'(exp_word(seg, br, on, i))) mism++;
      chk({name, "_seq_mism"}, 32'(mism), 32'd0);
   endtask

   typedef struct {
      logic [127:0] seg;
      logic [2:0]   br;
      logic         on;
      int           ign;
      int           chk_step;
      logic [17:0]  exp_chk;
      logic [17:0]  exp_last;
      int           exp_strobes;
   } vec_t;

   vec_t vecs[4];

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] s1;
      logic [127:0] s2;
      int d0;

      vecs[0] = '{128'hA5 << 24, 3'd7, 1'b1, 0, 4, 18'h3A5C3, 18'h2008F, 18};
      vecs[1] = '{128'h0F0E0D0C_0B0A0908_07060504_03020100, 3'd3, 1'b1, 0, 16, 18'h30FCF, 18'h2008B, 18};
      vecs[2] = '{{16{8'hFF}}, 3'd5, 1'b0, 1, 1, 18'h3FFC0, 18'h20085, 19};
      vecs[3] = '{128'h3C, 3'd0, 1'b1, 0, 1, 18'h33CC0, 18'h20088, 18};

      rst_n = 1'b0;
      update = 1'b0;
      segments = '0;
      bright = '0;
      disp_on = 1'b0;
      tick(); tick(); tick();
      chk("reset_outputs", {12'h0, busy, done, spi_ready, spi_data}, 32'h0);

      // Automatic first refresh after reset release
      rst_n = 1'b1;
      wait_done("auto");
      chk("auto_w0", word_at(0), 32'h20044);
      chk("auto_w1", word_at(1), 32'h300C0);
      chk("auto_w16", word_at(16), 32'h300CF);
      chk("auto_w17", word_at(17), 32'h20080);
      check_seq("auto", '0, 3'd0, 1'b0);
      tick(); tick();
      chk("auto_done_cnt", 32'(done_cnt), 32'd1);
      chk("auto_idle", {31'h0, busy}, 32'h0);

      // Table of single refreshes
      for (int v = 0; v < 4; v++) begin
         clear_logs();
         segments = vecs[v].seg;
         bright = vecs[v].br;
         disp_on = vecs[v].on;
         ignore_left = vecs[v].ign;
         pulse_update();
         wait_done($sformatf("v%0d", v));
         tick(); tick();
         chk($sformatf("v%0d_step", v), word_at(vecs[v].chk_step), 32'(vecs[v].exp_chk));
         chk($sformatf("v%0d_last", v), word_at(17), 32'(vecs[v].exp_last));
         chk($sformatf("v%0d_strobes", v), 32'(strobe_cnt), 32'(vecs[v].exp_strobes));
         chk($sformatf("v%0d_done", v), 32'(done_cnt), 32'd1);
         check_seq($sformatf("v%0d", v), vecs[v].seg, vecs[v].br, vecs[v].on);
         if (vecs[v].ign > 0)
            chk($sformatf("v%0d_restrobe", v), 32'(ign_word), word_at(0));
      end

      // Coalescing: three requests during a refresh yield one more refresh
      clear_logs();
      segments = 128'h1122;
      bright = 3'd1;
      disp_on = 1'b1;
      pulse_update();
      repeat (40) tick();
      pulse_update(); tick();
      pulse_update(); tick();
      pulse_update();
      wait_done("coal1");
      chk("coal_finish_busy", {30'h0, busy, done}, 32'h3);
      tick();
      chk("coal_idle_gap", {31'h0, busy}, 32'h0);
      tick();
      chk("coal_restart", {31'h0, busy}, 32'h1);
      wait_done("coal2");
      repeat (100) tick();
      chk("coal_done_cnt", 32'(done_cnt), 32'd2);
      chk("coal_words", 32'(words.size()), 32'd36);
      chk("coal_quiet", {31'h0, busy}, 32'h0);

      // Snapshot: inputs changed mid-refresh are not transmitted
      clear_logs();
      s1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
      segments = s1;
      bright = 3'd2;
      disp_on = 1'b1;
      pulse_update();
      repeat (60) tick();
      segments = ~s1;
      bright = 3'd5;
      disp_on = 1'b0;
      wait_done("snap");
      chk("snap_last", word_at(17), 32'h2008A);
      check_seq("snap", s1, 3'd2, 1'b1);
      tick(); tick();

      // Reset during step 9 abandons the refresh; a full one follows release
      clear_logs();
      s2 = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
      segments = s2;
      bright = 3'd6;
      disp_on = 1'b1;
      pulse_update();
      for (int c = 0; c < MAX_WAIT && words.size() < 10; c++) tick();
      chk("rst_reached_step9", 32'(words.size()), 32'd10);
      tick(); tick();
      chk("rst_pre_data", {13'h0, busy, spi_data}, {13'h1, exp_word(s2, 3'd6, 1'b1, 9)});
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_zero", {12'h0, busy, done, spi_ready, spi_data}, 32'h0);
      d0 = done_cnt;
      repeat (5) tick();
      chk("rst_no_done", 32'(done_cnt), 32'(d0));
      clear_logs();
      rst_n = 1'b1;
      wait_done("rst_rerun");
      check_seq("rst_rerun", s2, 3'd6, 1'b1);
      tick(); tick();
      chk("rst_rerun_done", 32'(done_cnt), 32'd1);

      chk("protocol_violations", 32'(proto_err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
